// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mips_pkg                                           |
// | Description : Shared types and constants for the fetch stage:    |
// |               fetch FSM states, buffer depth default and the     |
// |               {pc, instr} fetch-buffer entry.                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package mips_pkg;

  // Default number of instruction-buffer entries (power of two, >= 2)
  localparam int unsigned c_default_depth = 2;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    REQ  = 2'd1,  // request presented, waiting for grant
    RESP = 2'd2,  // granted, waiting for read data
    DROP = 2'd3   // granted request was killed, waiting to discard its data
  } fetch_state_e;

  // One fetch-buffer entry: word address and the instruction fetched from it
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_fifo                                         |
// | Description : Circular instruction buffer between fetch and      |
// |               decode. Clear has priority over push and pop.      |
// |               Head reads as zero while the buffer is empty.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = c_default_depth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;

  fetch_entry_t          r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // A clear kills any push or pop in the same cycle; popping an empty buffer is a no-op
  assign w_do_push = push && !clear;
  assign w_do_pop  = pop && !clear && (r_count != '0);

  // Entry storage; contents are only observed while the entry is valid, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ifetch                                             |
// | Description : Instruction fetch stage. Issues one word fetch at  |
// |               a time, reserving a buffer slot before issue, and  |
// |               discards responses belonging to killed requests.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module ifetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = c_default_depth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        pc_adv,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned        c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  fetch_state_e         r_state;
  fetch_state_e         w_next_state;
  logic [31:0]          r_addr_q;
  logic                 w_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue_ok;
  logic                 w_full;
  logic                 w_empty;
  logic [c_cnt_w-1:0]   w_count;
  logic [c_cnt_w-1:0]   w_outstanding;
  fetch_entry_t         w_push_entry;
  fetch_entry_t         w_head;

  // A granted, still-live request already owns a buffer slot
  assign w_outstanding = (r_state == RESP) ? c_cnt_w'(1) : '0;
  assign w_issue_ok    = ((w_count + w_outstanding) < c_depth) && !flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next_state = imem_gnt ? RESP : REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          w_next_state = flush ? DROP : RESP;
        end else if (flush) begin
          w_next_state = IDLE;
        end
      end
      RESP: begin
        if (flush) begin
          w_next_state = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          if (w_req) begin
            w_next_state = imem_gnt ? RESP : REQ;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: request and push decode; nothing is driven while in reset
  always_comb begin
    w_req  = 1'b0;
    w_push = 1'b0;
    case (r_state)
      IDLE: w_req = w_issue_ok;
      REQ:  w_req = 1'b1;
      RESP: begin
        if (imem_rvalid && !flush) begin
          w_push = 1'b1;
          w_req  = w_issue_ok;
        end
      end
      default: begin
        w_req  = 1'b0;
        w_push = 1'b0;
      end
    endcase
    if (rst) begin
      w_req  = 1'b0;
      w_push = 1'b0;
    end
  end

  // Remember the address of the granted request to tag its returning data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q <= '0;
    end else if (w_req && imem_gnt) begin
      r_addr_q <= pc;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_req ? pc : '0;
  assign pc_adv    = w_req && imem_gnt && !flush;

  assign w_push_entry.pc    = r_addr_q;
  assign w_push_entry.instr = imem_rdata;
  assign w_pop              = id_valid && id_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (flush),
    .din   (w_push_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign id_valid = !w_empty;
  assign id_instr = w_head.instr;
  assign id_pc    = w_head.pc;

  // Slot reservation at issue makes a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_push |-> !w_full)
    else $error("ifetch: push into full fetch buffer");

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ifetch                                          |
// | Description : Randomized scoreboard bench for ifetch. A driver   |
// |               plays PC stage, instruction memory and decode;     |
// |               expected buffer contents live in a queue that a    |
// |               separate monitor compares against the DUT.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_ifetch;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        pc_adv;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_adv      (pc_adv),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: entries the decode stage should see, oldest first
  fetch_entry_t exp_q[$];

  // Reference model of the single outstanding memory transaction
  bit          m_pend;
  bit          m_killed;
  logic [31:0] m_addr;

  // Memory responder state
  bit          mem_busy;
  int unsigned mem_delay;
  logic [31:0] mem_data;
  logic [31:0] tb_pc;

  // Stimulus knobs (percentages / delay range)
  int k_rst, k_gnt, k_rdy, k_fl, k_dmin, k_dmax;

  int n_checks;
  int n_pass;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle of stimulus, followed by the model's view of the coming edge
  task automatic step();
    fetch_entry_t e;
    @(negedge clk);
    rst         = (k_rst != 0);
    imem_rvalid = mem_busy && (mem_delay == 0);
    imem_rdata  = imem_rvalid ? mem_data : $urandom();
    imem_gnt    = (!mem_busy || mem_delay == 0) && (int'($urandom_range(99)) < k_gnt);
    id_ready    = (int'($urandom_range(99)) < k_rdy);
    flush       = (k_rst == 0) && (int'($urandom_range(99)) < k_fl);
    pc          = tb_pc;
    #2;
    if (rst) begin
      exp_q.delete();
      m_pend   = 0;
      m_killed = 0;
    end else begin
      if (flush) exp_q.delete();
      if (imem_rvalid && m_pend) begin
        if (!m_killed && !flush) begin
          e.pc    = m_addr;
          e.instr = imem_rdata;
          exp_q.push_back(e);
        end
        m_pend = 0;
      end
      if (m_pend && flush) m_killed = 1;
      if (imem_req && imem_gnt) begin
        m_pend   = 1;
        m_addr   = pc;
        m_killed = flush;
      end
    end
    if (mem_busy) begin
      if (mem_delay == 0) mem_busy = 0;
      else mem_delay--;
    end
    if (imem_req && imem_gnt) begin
      mem_busy  = 1;
      mem_delay = $urandom_range(k_dmax, k_dmin);
      mem_data  = ($urandom_range(3) == 0) ? 32'hDEAD_BEEF : $urandom();
    end
    if (rst) tb_pc = 32'h0;
    else if (flush) tb_pc = 32'h40 + {16'h0, 16'($urandom())};
    else if (pc_adv) tb_pc = tb_pc + 32'd1;
  endtask

  // Monitor: compares DUT outputs with the scoreboard every cycle
  initial begin : monitor
    int occ;
    int lat_req_cyc;
    bit lat_done;
    bit exp_req;
    bit exp_known;
    lat_req_cyc = -1;
    lat_done    = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("reset_ctrl", {29'h0, imem_req, pc_adv, id_valid}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_instr", id_instr, 32'h0);
        chk("reset_pc", id_pc, 32'h0);
      end else begin
        occ = exp_q.size();
        chk("id_valid", {31'h0, id_valid}, {31'h0, occ != 0});
        if (occ != 0) begin
          chk("id_pc", id_pc, exp_q[0].pc);
          chk("id_instr", id_instr, exp_q[0].instr);
          if (id_ready && !flush) void'(exp_q.pop_front());
        end else begin
          chk("empty_head", id_pc | id_instr, 32'h0);
        end
        chk("pc_adv", {31'h0, pc_adv}, {31'h0, imem_req && imem_gnt && !flush});
        if (imem_req) chk("imem_addr", imem_addr, pc);
        exp_known = 1;
        exp_req   = 0;
        if (m_pend) exp_req = imem_rvalid && !m_killed && !flush && (occ + 1 < DEPTH);
        else if (!flush) exp_req = (occ < DEPTH);
        else exp_known = 0;
        if (exp_known) chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        if (lat_req_cyc < 0 && imem_req) lat_req_cyc = cyc;
        if (!lat_done && id_valid) begin
          lat_done = 1;
          chk("first_latency", cyc - lat_req_cyc, 32'd2);
        end
      end
    end
  end

  // Driver: phase sequence
  initial begin : driver
    bit found;
    rst = 1'b1; flush = 1'b0; pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    tb_pc = '0; mem_busy = 0; mem_delay = 0; mem_data = '0;
    m_pend = 0; m_killed = 0; m_addr = '0;
    n_checks = 0; n_pass = 0; cyc = 0;
    k_rst = 1; k_gnt = 0; k_rdy = 0; k_fl = 0; k_dmin = 0; k_dmax = 0;
    repeat (3) step();

    // zero-wait memory, decode always ready
    k_rst = 0; k_gnt = 100; k_rdy = 100;
    repeat (12) step();

    // decode stalls: buffer fills and fetching stops
    k_rdy = 0;
    repeat (10) step();
    k_rdy = 100;
    repeat (6) step();

    // grant withheld for three cycles
    k_gnt = 0;
    repeat (3) step();
    k_gnt = 100;
    repeat (4) step();

    // randomized traffic with flushes and variable memory latency
    k_gnt = 60; k_rdy = 60; k_fl = 6; k_dmax = 3;
    repeat (3000) step();

    // flush with a full buffer while decode is ready
    k_fl = 0; k_rdy = 0; k_gnt = 100; k_dmax = 0;
    repeat (6) step();
    k_fl = 100; k_rdy = 100;
    step();
    k_fl = 0;
    repeat (4) step();

    // reset while a granted request is awaiting its data
    k_rdy = 0; k_dmin = 1; k_dmax = 1;
    repeat (4) step();
    k_rdy = 100;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_pend && !m_killed && mem_busy && mem_delay == 1) found = 1;
    end
    chk("resp_reached", {31'h0, found}, 32'h1);
    k_rst = 1;
    step();
    k_rst = 0; k_dmin = 0; k_dmax = 0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
